// File: rtl/dvi_sync_lock_if.sv
// DVI sync-lock bus: DE from the TMDS receiver in, lock status and measured mode out.
interface dvi_sync_lock_if #(
  parameter int CNT_W  = 12,
  parameter int VCNT_W = 11
);
  logic              de_in;
  logic              scdt_o;
  logic [CNT_W-1:0]  h_active_o;
  logic [CNT_W-1:0]  h_total_o;
  logic [VCNT_W-1:0] v_active_o;
  logic              v_valid_o;
  logic              mode_change_o;

  modport master (output de_in,
                  input  scdt_o, h_active_o, h_total_o, v_active_o, v_valid_o, mode_change_o);
  modport slave  (input  de_in,
                  output scdt_o, h_active_o, h_total_o, v_active_o, v_valid_o, mode_change_o);
endinterface

// File: rtl/dvi_sync_lock.sv
// DVI sync detect / mode lock: measures DE line timing and frame height, asserts scdt_o
// only after LOCK_LINES consistent lines, drops it on repeated bad lines or DE timeout.
module dvi_sync_lock #(
  parameter int CNT_W        = 12,
  parameter int VCNT_W       = 11,
  parameter int TIMEOUT      = 20000,
  parameter int LOCK_LINES   = 4,
  parameter int UNLOCK_LINES = 2,
  parameter int TOL          = 1
) (
  input  logic           odck_in,
  input  logic           rst,
  dvi_sync_lock_if.slave bus
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int GC_W   = $clog2(LOCK_LINES + 1);
  localparam int BC_W   = $clog2(UNLOCK_LINES + 1);

  localparam logic [CNT_W-1:0]  CMAX      = {CNT_W{1'b1}};
  localparam logic [VCNT_W-1:0] VMAX      = {VCNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  TOL_C     = CNT_W'(TOL);
  localparam logic [IDLE_W-1:0] TIMEOUT_C = IDLE_W'(TIMEOUT);
  localparam logic [GC_W-1:0]   LOCK_C    = GC_W'(LOCK_LINES);
  localparam logic [BC_W-1:0]   UNLOCK_C  = BC_W'(UNLOCK_LINES);

  typedef enum logic [1:0] {NOSIG, ACQ, LOCK} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
    return (a == CMAX) ? CMAX : a + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] absdiff(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  state_e             state_q, state_d;
  logic               de_r_q, de_r_d, de_rr_q, de_rr_d;
  logic [CNT_W-1:0]   act_cnt_q, act_cnt_d, act_len_q, act_len_d, per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]   prev_act_q, prev_act_d, prev_per_q, prev_per_d;
  logic               has_ref_q, has_ref_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [GC_W-1:0]    good_cnt_q, good_cnt_d;
  logic [BC_W-1:0]    bad_cnt_q, bad_cnt_d;
  logic [VCNT_W-1:0]  line_cnt_q, line_cnt_d;
  logic               seen_bnd_q, seen_bnd_d;
  logic               locked_once_q, locked_once_d;
  logic [CNT_W-1:0]   h_active_q, h_active_d, h_total_q, h_total_d;
  logic [VCNT_W-1:0]  v_active_q, v_active_d;
  logic               v_valid_q, v_valid_d;
  logic               mode_chg_q, mode_chg_d;
  logic               scdt_q, scdt_d;

  logic               rise, fall, timeout, line_done, line_good, frame_bnd;
  logic [CNT_W-1:0]   per_len, gap;

  assign rise      = de_r_q & ~de_rr_q;
  assign fall      = ~de_r_q & de_rr_q;
  assign per_len   = sat_inc(per_cnt_q);
  assign timeout   = (idle_cnt_q == TIMEOUT_C);
  assign line_done = rise && (state_q != NOSIG);
  // A saturated length means the counter overflowed, so it can never be trusted.
  assign line_good = has_ref_q && (per_len != CMAX) && (act_len_q != CMAX) &&
                     (absdiff(per_len, prev_per_q) <= TOL_C) &&
                     (absdiff(act_len_q, prev_act_q) <= TOL_C);
  assign gap       = (per_len > act_len_q) ? per_len - act_len_q : '0;
  assign frame_bnd = gap > h_total_q;

  always_comb begin
    de_r_d        = bus.de_in;
    de_rr_d       = de_r_q;
    act_cnt_d     = rise ? '0 : (de_r_q ? sat_inc(act_cnt_q) : act_cnt_q);
    act_len_d     = fall ? sat_inc(act_cnt_q) : act_len_q;
    per_cnt_d     = rise ? '0 : sat_inc(per_cnt_q);
    idle_cnt_d    = rise ? '0 : (timeout ? idle_cnt_q : idle_cnt_q + 1'b1);
    state_d       = state_q;
    prev_act_d    = prev_act_q;
    prev_per_d    = prev_per_q;
    has_ref_d     = has_ref_q;
    good_cnt_d    = good_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    line_cnt_d    = line_cnt_q;
    seen_bnd_d    = seen_bnd_q;
    locked_once_d = locked_once_q;
    h_active_d    = h_active_q;
    h_total_d     = h_total_q;
    v_active_d    = v_active_q;
    v_valid_d     = v_valid_q;
    mode_chg_d    = 1'b0;
    scdt_d        = (state_q == LOCK);

    if (line_done) begin
      prev_per_d = per_len;
      prev_act_d = act_len_q;
      has_ref_d  = 1'b1;
    end

    case (state_q)
      NOSIG: if (rise) state_d = ACQ;
      ACQ: if (line_done) begin
        if (line_good) begin
          if (good_cnt_q + 1'b1 == LOCK_C) begin
            state_d       = LOCK;
            h_active_d    = act_len_q;
            h_total_d     = per_len;
            mode_chg_d    = !locked_once_q || (act_len_q != h_active_q) || (per_len != h_total_q);
            locked_once_d = 1'b1;
            good_cnt_d    = '0;
            bad_cnt_d     = '0;
            line_cnt_d    = '0;
            seen_bnd_d    = 1'b0;
          end else begin
            good_cnt_d = good_cnt_q + 1'b1;
          end
        end else begin
          good_cnt_d = '0;
        end
      end
      LOCK: if (line_done) begin
        // The boundary line itself is line 1 of the new frame; the first frame is partial.
        if (frame_bnd) begin
          line_cnt_d = {{(VCNT_W-1){1'b0}}, 1'b1};
          seen_bnd_d = 1'b1;
          if (seen_bnd_q) begin
            v_active_d = line_cnt_q;
            v_valid_d  = 1'b1;
          end
        end else if (line_cnt_q != VMAX) begin
          line_cnt_d = line_cnt_q + 1'b1;
        end
        if (line_good) begin
          bad_cnt_d = '0;
        end else if (bad_cnt_q + 1'b1 == UNLOCK_C) begin
          state_d    = ACQ;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
          v_valid_d  = 1'b0;
        end else begin
          bad_cnt_d = bad_cnt_q + 1'b1;
        end
      end
      default: state_d = NOSIG;
    endcase

    // Loss of DE overrides anything a coincident line completion decided.
    if (timeout && state_q != NOSIG) begin
      state_d       = NOSIG;
      good_cnt_d    = '0;
      bad_cnt_d     = '0;
      v_valid_d     = 1'b0;
      has_ref_d     = 1'b0;
      mode_chg_d    = 1'b0;
      h_active_d    = h_active_q;
      h_total_d     = h_total_q;
      locked_once_d = locked_once_q;
    end
  end

  always_ff @(posedge odck_in or negedge rst) begin
    if (!rst) begin
      state_q       <= NOSIG;
      de_r_q        <= 1'b0;
      de_rr_q       <= 1'b0;
      act_cnt_q     <= '0;
      act_len_q     <= '0;
      per_cnt_q     <= '0;
      prev_act_q    <= '0;
      prev_per_q    <= '0;
      has_ref_q     <= 1'b0;
      idle_cnt_q    <= '0;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      line_cnt_q    <= '0;
      seen_bnd_q    <= 1'b0;
      locked_once_q <= 1'b0;
      h_active_q    <= '0;
      h_total_q     <= '0;
      v_active_q    <= '0;
      v_valid_q     <= 1'b0;
      mode_chg_q    <= 1'b0;
      scdt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      de_r_q        <= de_r_d;
      de_rr_q       <= de_rr_d;
      act_cnt_q     <= act_cnt_d;
      act_len_q     <= act_len_d;
      per_cnt_q     <= per_cnt_d;
      prev_act_q    <= prev_act_d;
      prev_per_q    <= prev_per_d;
      has_ref_q     <= has_ref_d;
      idle_cnt_q    <= idle_cnt_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      line_cnt_q    <= line_cnt_d;
      seen_bnd_q    <= seen_bnd_d;
      locked_once_q <= locked_once_d;
      h_active_q    <= h_active_d;
      h_total_q     <= h_total_d;
      v_active_q    <= v_active_d;
      v_valid_q     <= v_valid_d;
      mode_chg_q    <= mode_chg_d;
      scdt_q        <= scdt_d;
    end
  end

  assign bus.scdt_o        = scdt_q;
  assign bus.h_active_o    = h_active_q;
  assign bus.h_total_o     = h_total_q;
  assign bus.v_active_o    = v_active_q;
  assign bus.v_valid_o     = v_valid_q;
  assign bus.mode_change_o = mode_chg_q;

endmodule

// File: tb/tb_dvi_sync_lock.sv
// Directed bench for dvi_sync_lock: full-size instance for lock/unlock/timeout/reset,
// small-timing instance for frame height measurement.
module tb_dvi_sync_lock;
  logic odck_in = 1'b0;
  logic rst     = 1'b0;
  always #5 odck_in = ~odck_in;

  dvi_sync_lock_if #(.CNT_W(12), .VCNT_W(11)) b1();
  dvi_sync_lock_if #(.CNT_W(8),  .VCNT_W(6))  b2();

  dvi_sync_lock #(.CNT_W(12), .VCNT_W(11), .TIMEOUT(20000), .LOCK_LINES(4),
                  .UNLOCK_LINES(2), .TOL(1))
    dut (.odck_in(odck_in), .rst(rst), .bus(b1));

  // Short lines and a third unlock strike so frame blanking neither times out nor unlocks.
  dvi_sync_lock #(.CNT_W(8), .VCNT_W(6), .TIMEOUT(200), .LOCK_LINES(4),
                  .UNLOCK_LINES(3), .TOL(1))
    dut_v (.odck_in(odck_in), .rst(rst), .bus(b2));

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   mc_cnt = 0;

  always @(negedge odck_in) if (b1.mode_change_o === 1'b1) mc_cnt++;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return 32'(b1.scdt_o);
      1:       return 32'(b1.h_active_o);
      2:       return 32'(b1.h_total_o);
      3:       return 32'(b1.v_active_o);
      4:       return 32'(b1.v_valid_o);
      5:       return 32'(mc_cnt);
      6:       return 32'(b2.scdt_o);
      7:       return 32'(b2.v_active_o);
      8:       return 32'(b2.v_valid_o);
      9:       return 32'(b1.mode_change_o);
      default: return 'x;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = observe(e.sel);
      n_cmp++;
      assert (o === e.exp) else begin
        n_bad++;
        $error("FAIL %s: got %0d expected %0d", e.tag, o, e.exp);
      end
    end
  endtask

  // Called on a negedge; DE period is exactly h+l cycles.
  task automatic line(input int which, input int h, input int l);
    if (which == 1) b1.de_in = 1'b1; else b2.de_in = 1'b1;
    repeat (h) @(negedge odck_in);
    if (which == 1) b1.de_in = 1'b0; else b2.de_in = 1'b0;
    repeat (l) @(negedge odck_in);
  endtask

  initial begin
    b1.de_in = 1'b0;
    b2.de_in = 1'b0;
    rst      = 1'b0;
    repeat (3) @(negedge odck_in);
    push_exp("rst_scdt", 0, 0);
    push_exp("rst_hact", 1, 0);
    push_exp("rst_htot", 2, 0);
    push_exp("rst_vact", 3, 0);
    push_exp("rst_vval", 4, 0);
    push_exp("rst_scdt_v", 6, 0);
    drain();
    rst = 1'b1;
    @(negedge odck_in);

    // Frame height on the small instance: 12-line frames, 3 blank lines.
    repeat (5) line(2, 8, 8);
    push_exp("t5_prelock", 6, 0);
    drain();
    line(2, 8, 8);
    push_exp("t5_lock", 6, 1);
    drain();
    for (int f = 0; f < 4; f++) begin
      for (int n = 0; n < 12; n++) begin
        line(2, 8, (n == 11) ? 56 : 8);
        if (f == 1 && n == 0) push_exp("t5_first_bnd_vval", 8, 0);
        if (f >= 2 && n == 0) begin
          push_exp("t5_vact", 7, 12);
          push_exp("t5_vval", 8, 1);
        end
        if (n == 1) push_exp("t5_hold_after_bnd", 6, 1);
        drain();
      end
    end

    // Lock from reset, exact scdt latency.
    repeat (5) line(1, 800, 800);
    push_exp("t1_before_6th", 0, 0);
    push_exp("t1_no_mc_yet", 5, 0);
    drain();
    b1.de_in = 1'b1;
    @(negedge odck_in);
    push_exp("t1_lat_e0", 0, 0);
    drain();
    @(negedge odck_in);
    push_exp("t1_lat_e1", 0, 0);
    drain();
    @(negedge odck_in);
    push_exp("t1_lat_e2", 0, 1);
    drain();
    repeat (797) @(negedge odck_in);
    b1.de_in = 1'b0;
    repeat (800) @(negedge odck_in);
    push_exp("t1_hact", 1, 800);
    push_exp("t1_htot", 2, 1600);
    push_exp("t1_mc", 5, 1);
    drain();

    // One long line then back: two bad lines unlock, four good relock.
    line(1, 800, 810);
    push_exp("t3_pre", 0, 1);
    drain();
    line(1, 800, 800);
    push_exp("t3_one_bad", 0, 1);
    drain();
    line(1, 800, 800);
    push_exp("t3_unlock", 0, 0);
    drain();
    repeat (3) line(1, 800, 800);
    push_exp("t3_acq", 0, 0);
    push_exp("t3_hold_hact", 1, 800);
    drain();
    line(1, 800, 800);
    push_exp("t3_relock", 0, 1);
    push_exp("t3_htot", 2, 1600);
    push_exp("t3_no_mc", 5, 1);
    drain();

    // Jitter within TOL keeps lock.
    for (int i = 0; i < 6; i++) begin
      line(1, 800, (i % 2 == 0) ? 801 : 800);
      push_exp("t4_jitter_lock", 0, 1);
      drain();
    end
    push_exp("t4_htot", 2, 1600);
    push_exp("t4_mc", 5, 1);
    drain();

    // Async reset mid-line while locked.
    b1.de_in = 1'b1;
    repeat (100) @(negedge odck_in);
    #2 rst = 1'b0;
    #1;
    push_exp("t6_scdt", 0, 0);
    push_exp("t6_hact", 1, 0);
    push_exp("t6_htot", 2, 0);
    push_exp("t6_vact", 3, 0);
    push_exp("t6_vval", 4, 0);
    push_exp("t6_mc_out", 9, 0);
    drain();
    b1.de_in = 1'b0;
    repeat (3) @(negedge odck_in);
    rst = 1'b1;
    repeat (5) line(1, 800, 800);
    push_exp("t6_before_6th", 0, 0);
    drain();
    line(1, 800, 800);
    push_exp("t6_relock", 0, 1);
    push_exp("t6_hact", 1, 800);
    push_exp("t6_htot", 2, 1600);
    push_exp("t6_mc", 5, 2);
    drain();

    // DE stops: scdt drops about TIMEOUT cycles after the last rise.
    repeat (19990 - 1600) @(negedge odck_in);
    push_exp("t2_before_to", 0, 1);
    drain();
    repeat (20) @(negedge odck_in);
    push_exp("t2_timeout", 0, 0);
    push_exp("t2_vval", 4, 0);
    push_exp("t2_hold_hact", 1, 800);
    push_exp("t2_hold_htot", 2, 1600);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
